// File: rtl/wb_trace_buffer_if.sv
// Trace output stream of the writeback trace buffer.
// The buffer drives the head entry; the consumer drives ready.
interface wb_trace_buffer_if #(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int SEQ_WIDTH  = 8
);
  logic                  trace_valid_o;
  logic                  trace_ready_i;
  logic [ADDR_WIDTH-1:0] trace_addr_o;
  logic [WORD-1:0]       trace_data_o;
  logic [SEQ_WIDTH-1:0]  trace_seq_o;

  modport master (
    output trace_valid_o,
    input  trace_ready_i,
    output trace_addr_o,
    output trace_data_o,
    output trace_seq_o
  );

  modport slave (
    input  trace_valid_o,
    output trace_ready_i,
    input  trace_addr_o,
    input  trace_data_o,
    input  trace_seq_o
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: filters register writes by a watch mask
// and queues {addr, data, seq} in a first-word-fall-through FIFO.
module wb_trace_buffer #(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int SEQ_WIDTH  = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       reg_file_write_en_i,
  input  logic [ADDR_WIDTH-1:0]      reg_dest_addr_i,
  input  logic [WORD-1:0]            reg_data_i,
  input  logic [2**ADDR_WIDTH-1:0]   watch_mask_i,
  input  logic                       enable_i,
  input  logic                       clear_i,
  wb_trace_buffer_if.master          trace_if,
  output logic [WORD-1:0]            last_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [CNT_WIDTH-1:0]       overflow_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic [CNT_WIDTH-1:0] ovf_q, ovf_d;
  logic [WORD-1:0]      last_q, last_d;

  logic [ADDR_WIDTH-1:0] mem_addr_q [DEPTH];
  logic [WORD-1:0]       mem_data_q [DEPTH];
  logic [SEQ_WIDTH-1:0]  mem_seq_q  [DEPTH];

  logic qual, full, empty, push, pop, drop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign qual = reg_file_write_en_i & enable_i
              & watch_mask_i[reg_dest_addr_i];

  // clear wins over both sides of the FIFO in its cycle
  assign pop  = ~empty & trace_if.trace_ready_i & ~clear_i;
  assign push = qual & ~clear_i & (~full | pop);
  assign drop = qual & ~clear_i & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    seq_d    = seq_q;
    ovf_d    = ovf_q;
    last_d   = last_q;
    if (qual) begin
      last_d = reg_data_i;
    end
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      seq_d    = '0;
      ovf_d    = '0;
    end else begin
      if (qual) begin
        seq_d = seq_q + 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (drop && ovf_q != '1) begin
        ovf_d = ovf_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      ovf_q    <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
    end
  end

  // storage is not reset; head outputs are don't-care while empty
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      mem_addr_q[wr_ptr_q] <= reg_dest_addr_i;
      mem_data_q[wr_ptr_q] <= reg_data_i;
      mem_seq_q[wr_ptr_q]  <= seq_q;
    end
  end

  assign trace_if.trace_valid_o = ~empty;
  assign trace_if.trace_addr_o  = mem_addr_q[rd_ptr_q];
  assign trace_if.trace_data_o  = mem_data_q[rd_ptr_q];
  assign trace_if.trace_seq_o   = mem_seq_q[rd_ptr_q];

  assign last_data_o    = last_q;
  assign count_o        = count_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign overflow_cnt_o = ovf_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: stimulus queues expected
// entries, a negedge monitor checks every handshake.
module tb_wb_trace_buffer;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
    logic [7:0]  s;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [15:0] mask = '0;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic [31:0] last;
  logic [3:0]  cnt;
  logic        full, empty;
  logic [7:0]  ovf;

  int checks = 0;
  int errors = 0;
  ent_t exp_q[$];

  wb_trace_buffer_if #(.WORD(32), .ADDR_WIDTH(4), .SEQ_WIDTH(8)) tif();

  wb_trace_buffer #(
    .WORD(32), .ADDR_WIDTH(4), .DEPTH(8),
    .SEQ_WIDTH(8), .CNT_WIDTH(8)
  ) dut (
    .clk_i              (clk),
    .reset_i            (rst),
    .reg_file_write_en_i(we),
    .reg_dest_addr_i    (wa),
    .reg_data_i         (wd),
    .watch_mask_i       (mask),
    .enable_i           (en),
    .clear_i            (clr),
    .trace_if           (tif),
    .last_data_o        (last),
    .count_o            (cnt),
    .full_o             (full),
    .empty_o            (empty),
    .overflow_cnt_o     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  // monitor: a handshake seen at negedge completes at the next edge
  always @(negedge clk) begin
    if (!rst && !clr && tif.trace_valid_o && tif.trace_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop seq=%0d", tif.trace_seq_o);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("pop_addr", 64'(tif.trace_addr_o), 64'(e.a));
        chk("pop_data", 64'(tif.trace_data_o), 64'(e.d));
        chk("pop_seq", 64'(tif.trace_seq_o), 64'(e.s));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    tick();
    we = 1'b0;
  endtask

  task automatic expect_e(input logic [3:0] a, input logic [31:0] d,
                          input logic [7:0] s);
    ent_t e;
    e.a = a;
    e.d = d;
    e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    tif.trace_ready_i = 1'b1;
    while (!empty && n < 40) begin
      tick();
      n++;
    end
    tif.trace_ready_i = 1'b0;
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_sb_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fill8(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      wr(4'(i), base + 32'(i));
      expect_e(4'(i), base + 32'(i), 8'(i));
    end
  endtask

  initial begin
    tif.trace_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 64'(cnt), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_valid", 64'(tif.trace_valid_o), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_last", 64'(last), 64'd0);

    // basic capture
    mask = 16'h0001;
    wr(4'd0, 32'hDEADBEEF);
    expect_e(4'd0, 32'hDEADBEEF, 8'd0);
    chk("cap_valid", 64'(tif.trace_valid_o), 64'd1);
    chk("cap_addr", 64'(tif.trace_addr_o), 64'd0);
    chk("cap_data", 64'(tif.trace_data_o), 64'hDEADBEEF);
    chk("cap_seq", 64'(tif.trace_seq_o), 64'd0);
    chk("cap_count", 64'(cnt), 64'd1);
    chk("cap_last", 64'(last), 64'hDEADBEEF);
    drain();

    // filtering
    do_clear();
    mask = 16'h0006;
    wr(4'd1, 32'hA1);
    wr(4'd3, 32'hA3);
    wr(4'd2, 32'hA2);
    expect_e(4'd1, 32'hA1, 8'd0);
    expect_e(4'd2, 32'hA2, 8'd1);
    chk("filt_count", 64'(cnt), 64'd2);
    chk("filt_last", 64'(last), 64'hA2);
    drain();

    // enable low captures nothing
    en = 1'b0;
    wr(4'd1, 32'hBAD);
    chk("dis_count", 64'(cnt), 64'd0);
    en = 1'b1;

    // overflow
    do_clear();
    mask = 16'hFFFF;
    fill8(32'h100);
    wr(4'd8, 32'h108);
    wr(4'd9, 32'h109);
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_count", 64'(cnt), 64'd8);
    chk("ovf_cnt", 64'(ovf), 64'd2);
    chk("ovf_last", 64'(last), 64'h109);
    drain();
    wr(4'd10, 32'h10A);
    expect_e(4'd10, 32'h10A, 8'd10);
    chk("ovf_seq10", 64'(tif.trace_seq_o), 64'd10);
    drain();

    // full with simultaneous pop
    do_clear();
    fill8(32'h200);
    tif.trace_ready_i = 1'b1;
    wr(4'd8, 32'h208);
    tif.trace_ready_i = 1'b0;
    expect_e(4'd8, 32'h208, 8'd8);
    chk("fp_count", 64'(cnt), 64'd8);
    chk("fp_ovf", 64'(ovf), 64'd0);
    drain();

    // pointer wrap with continuous ready
    do_clear();
    tif.trace_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      expect_e(4'(i), 32'h300 + 32'(i), 8'(i));
      wr(4'(i), 32'h300 + 32'(i));
      chk("wrap_valid", 64'(tif.trace_valid_o), 64'd1);
      chk("wrap_seq", 64'(tif.trace_seq_o), 64'(i));
      chk("wrap_count", 64'(cnt), 64'd1);
    end
    tick();
    tif.trace_ready_i = 1'b0;
    chk("wrap_empty", 64'(empty), 64'd1);
    chk("wrap_sb_left", 64'(exp_q.size()), 64'd0);

    // clear with concurrent write while holding 5 entries
    do_clear();
    fill8(32'h400);
    wr(4'd8, 32'h408);
    tif.trace_ready_i = 1'b1;
    tick();
    tick();
    tick();
    tif.trace_ready_i = 1'b0;
    chk("clr_pre_count", 64'(cnt), 64'd5);
    chk("clr_pre_ovf", 64'(ovf), 64'd1);
    clr = 1'b1;
    tif.trace_ready_i = 1'b1;
    wr(4'd1, 32'h4FF);
    clr = 1'b0;
    tif.trace_ready_i = 1'b0;
    exp_q.delete();
    chk("clr_count", 64'(cnt), 64'd0);
    chk("clr_ovf", 64'(ovf), 64'd0);
    chk("clr_empty", 64'(empty), 64'd1);
    wr(4'd5, 32'h455);
    expect_e(4'd5, 32'h455, 8'd0);
    chk("clr_seq0", 64'(tif.trace_seq_o), 64'd0);
    drain();

    // reset mid-drain
    for (int i = 0; i < 4; i++) begin
      wr(4'(i), 32'h500 + 32'(i));
      expect_e(4'(i), 32'h500 + 32'(i), 8'(i + 1));
    end
    tif.trace_ready_i = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tif.trace_ready_i = 1'b0;
    exp_q.delete();
    chk("mrst_count", 64'(cnt), 64'd0);
    chk("mrst_valid", 64'(tif.trace_valid_o), 64'd0);
    chk("mrst_full", 64'(full), 64'd0);
    chk("mrst_ovf", 64'(ovf), 64'd0);
    chk("mrst_last", 64'(last), 64'd0);
    wr(4'd7, 32'h577);
    expect_e(4'd7, 32'h577, 8'd0);
    chk("mrst_seq0", 64'(tif.trace_seq_o), 64'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WORD, default 32: register data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4: register address width; the watch mask is 2**ADDR_WIDTH bits wide.
REQ-003 The block SHALL have parameter DEPTH, default 8: FIFO entries; legal values are powers of two, 2 or more.
REQ-004 The block SHALL have parameter SEQ_WIDTH, default 8: width of the sequence tag.
REQ-005 The block SHALL have parameter CNT_WIDTH, default 8: width of the overflow counter.

Ports (name, direction, width, meaning):
REQ-006 The block SHALL have port clk_i, input, 1: the single clock, rising edge.
REQ-007 The block SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-008 The block SHALL have port reg_file_write_en_i, input, 1: writeback register-write strobe.
REQ-009 The block SHALL have port reg_dest_addr_i, input, ADDR_WIDTH: writeback destination register.
REQ-010 The block SHALL have port reg_data_i, input, WORD: writeback data.
REQ-011 The block SHALL have port watch_mask_i, input, 2**ADDR_WIDTH: bit r set means writes to register r are traced.
REQ-012 The block SHALL have port enable_i, input, 1: capture enable.
REQ-013 The block SHALL have port clear_i, input, 1: synchronous flush of the FIFO and the counters.
REQ-014 The block SHALL have port trace_ready_i, input, 1: consumer ready.
REQ-015 The block SHALL have port trace_valid_o, output, 1: the head entry is valid.
REQ-016 The block SHALL have port trace_addr_o, output, ADDR_WIDTH: head entry register address.
REQ-017 The block SHALL have port trace_data_o, output, WORD: head entry data.
REQ-018 The block SHALL have port trace_seq_o, output, SEQ_WIDTH: head entry sequence tag.
REQ-019 The block SHALL have port last_data_o, output, WORD: data of the most recent qualifying write.
REQ-020 The block SHALL have port count_o, output, clog2(DEPTH)+1: current occupancy.
REQ-021 The block SHALL have port full_o, output, 1: count_o equals DEPTH.
REQ-022 The block SHALL have port empty_o, output, 1: count_o equals 0.
REQ-023 The block SHALL have port overflow_cnt_o, output, CNT_WIDTH: number of dropped events.

Function
REQ-024 A qualifying write SHALL be a cycle with reg_file_write_en_i=1, enable_i=1 and watch_mask_i[reg_dest_addr_i]=1.
REQ-025 Each qualifying write SHALL be tagged with the internal sequence counter value, and that counter SHALL increment modulo 2**SEQ_WIDTH on every qualifying write, whether accepted or dropped.
REQ-026 A qualifying write SHALL be pushed as {addr, data, seq} if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
REQ-027 A qualifying write arriving when the FIFO is full with no pop in that cycle SHALL be dropped, and overflow_cnt_o SHALL increment, saturating at all-ones.
REQ-028 The FIFO SHALL be first-word-fall-through: trace_valid_o equals !empty_o, and trace_addr_o, trace_data_o and trace_seq_o present the head entry combinationally from storage.
REQ-029 A pop SHALL occur when trace_valid_o=1 and trace_ready_i=1.
REQ-030 trace_ready_i SHALL be ignored while the FIFO is empty.
REQ-031 Latency SHALL be one cycle: a write accepted at edge N into an empty FIFO gives trace_valid_o=1 after edge N.
REQ-032 On a simultaneous push and pop, count_o SHALL be unchanged and ordering SHALL be preserved.
REQ-033 When the FIFO is empty, a same-cycle push and ready SHALL NOT pop the entry being pushed.
REQ-034 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-035 last_data_o SHALL update on every qualifying write, including dropped ones.
REQ-036 last_data_o SHALL be unaffected by clear_i.
REQ-037 When clear_i=1, the next edge SHALL empty the FIFO (pointers to 0, count to 0), zero the sequence counter and zero overflow_cnt_o.
REQ-038 A write qualifying in the same cycle as clear_i SHALL be discarded and SHALL NOT be counted.
REQ-039 A trace_ready_i asserted in the same cycle as clear_i SHALL be ignored.
REQ-040 When enable_i=0, the block SHALL capture nothing, while draining SHALL continue normally.
REQ-041 watch_mask_i and enable_i SHALL be sampled every cycle and SHALL take effect immediately; no internal copy is held.

Reset
REQ-042 When reset_i=1 at a rising edge, the block SHALL set: pointers=0, count_o=0, empty_o=1, full_o=0, trace_valid_o=0, sequence counter=0, overflow_cnt_o=0, last_data_o=0.
REQ-043 reset_i SHALL override clear_i and any concurrent push or pop.
REQ-044 FIFO storage contents SHALL NOT be reset; the trace_addr_o, trace_data_o and trace_seq_o outputs are don't-care while trace_valid_o=0.
REQ-045 A reset asserted mid-drain SHALL discard all entries; after reset deasserts, the first captured entry SHALL carry seq=0.

Verification
REQ-046 The bench SHALL cover basic capture: mask=0x0001, ready=0, write r0=0xDEADBEEF -> the next cycle shows valid=1, addr=0, data=0xDEADBEEF, seq=0, count=1, last_data_o=0xDEADBEEF.
REQ-047 The bench SHALL cover filtering: mask=0x0006, writes to r1, r3, r2 -> exactly two entries, (1, seq0) then (2, seq1); r3 is not counted.
REQ-048 The bench SHALL cover overflow: DEPTH=8, ready=0, 10 qualifying writes -> full_o=1, count=8, overflow_cnt_o=2; draining yields seq 0..7; an 11th write accepted after draining carries seq=10.
REQ-049 The bench SHALL cover full with simultaneous pop: FIFO full, write and ready in the same cycle -> count stays 8, overflow_cnt_o unchanged, the new entry appears last.
REQ-050 The bench SHALL cover pointer wrap: ready=1 continuously, 20 consecutive writes -> each entry appears one cycle after its write, in order, with count never above 1.
REQ-051 The bench SHALL cover clear and reset: clear_i with a concurrent write while holding 5 entries -> count=0, overflow=0, and the next captured entry has seq=0; reset_i mid-drain -> outputs at reset values and last_data_o=0.
